// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- parametrised integer register file with a per-register
// scoreboard (busy bit) for RAW hazard detection at decode.
//
// Register 0 is hardwired: it reads as zero, is never busy, and writes or
// issues that target it are dropped.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   -> a writeback in the current cycle is forwarded to any read
//                port addressing the same register, and masks that port's
//                busy flag unless the same register is also issuing.
//   undefined -> reads always reflect stored state.
//
// Parameters:
//   XLEN  data width in bits
//   NREG  register count (power of two, >= 2)
//   NRP   number of read ports (1..4)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   RAddr_RF    read addresses, port p at [p*AW +: AW]
//   RD_RF       read data, port p at [p*XLEN +: XLEN]
//   RBusy_RF    busy flag of the register addressed by each port
//   WrEn_RF     writeback enable
//   WAddr_RF    writeback address
//   WD_RF       writeback data
//   IssEn_RF    issue enable, marks IssAddr_RF busy
//   IssAddr_RF  destination register of the issuing instruction
//   BusyCnt_RF  number of registers currently busy (registered)
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRP  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRP*AW-1:0]    RAddr_RF,
  output logic [NRP*XLEN-1:0]  RD_RF,
  output logic [NRP-1:0]       RBusy_RF,
  input  logic                 WrEn_RF,
  input  logic [AW-1:0]        WAddr_RF,
  input  logic [XLEN-1:0]      WD_RF,
  input  logic                 IssEn_RF,
  input  logic [AW-1:0]        IssAddr_RF,
  output logic [AW:0]          BusyCnt_RF
);

  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [NREG-1:1] busy_q;
  logic [AW:0]     busy_cnt_q;

  logic wr_v;
  logic iss_v;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_v  = WrEn_RF  && (WAddr_RF   != '0);
  assign iss_v = IssEn_RF && (IssAddr_RF != '0);

  // The counter tracks the busy vector incrementally. An issue adds one only
  // when the target was idle; a write removes one only when its target was
  // busy and is not being re-issued in the same cycle (issue wins).
  assign cnt_inc = iss_v && !busy_q[IssAddr_RF];
  assign cnt_dec = wr_v  &&  busy_q[WAddr_RF] &&
                   !(iss_v && (IssAddr_RF == WAddr_RF));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data array is reset as well, because reads of any register
      // must return zero after reset; this rules out a RAM macro here.
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments -- the issue update below is the later
      // assignment to the same busy bit, so it overrides the write's clear.
      if (wr_v) begin
        regs_q[WAddr_RF] <= WD_RF;
        busy_q[WAddr_RF] <= 1'b0;
      end
      if (iss_v) begin
        busy_q[IssAddr_RF] <= 1'b1;
      end
      busy_cnt_q <= busy_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  assign BusyCnt_RF = busy_cnt_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rport
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rbusy;

    assign ra = RAddr_RF[p*AW +: AW];

    always_comb begin
      // NOTE: defaults first so every path assigns both outputs (no latch).
      rd    = '0;
      rbusy = 1'b0;
      if (ra != '0) begin
        rd    = regs_q[ra];
        rbusy = busy_q[ra];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_v && (WAddr_RF == ra)) begin
        rd    = WD_RF;
        rbusy = iss_v && (IssAddr_RF == ra);
      end
`endif
    end

    assign RD_RF[p*XLEN +: XLEN] = rd;
    assign RBusy_RF[p]           = rbusy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- self-checking bench for regfile_sb (two read ports).
// A reference model (plain arrays updated by the architectural rules) predicts
// every read port and the busy count each cycle; directed steps cover the
// documented scenarios, followed by randomized traffic with occasional resets.
// Build with +define+REGFILE_BYPASS_EN to check the forwarding variant.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = $clog2(NREG);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rd;
  logic [NRP-1:0]      rbusy;
  logic                wr_en;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wd;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW:0]         busy_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state.
  logic [XLEN-1:0] ref_reg  [NREG];
  bit              ref_busy [NREG];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RAddr_RF   (raddr),
    .RD_RF      (rd),
    .RBusy_RF   (rbusy),
    .WrEn_RF    (wr_en),
    .WAddr_RF   (waddr),
    .WD_RF      (wd),
    .IssEn_RF   (iss_en),
    .IssAddr_RF (iss_addr),
    .BusyCnt_RF (busy_cnt)
  );

  function automatic logic [XLEN-1:0] rd_port(input int p);
    return rd[p*XLEN +: XLEN];
  endfunction

  function automatic int ref_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += ref_busy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every read port and the busy count against the model, taking the
  // current-cycle inputs into account for the forwarding variant.
  task automatic check_outputs();
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] exp_d;
      logic            exp_b;
      a     = raddr[p*AW +: AW];
      exp_d = (a == 0) ? '0 : ref_reg[a];
      exp_b = (a == 0) ? 1'b0 : ref_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && waddr != 0 && waddr == a) begin
        exp_d = wd;
        exp_b = iss_en && iss_addr == a;
      end
`endif
      check($sformatf("rd_p%0d_r%0d", p, a), 64'(rd_port(p)), 64'(exp_d));
      check($sformatf("rbusy_p%0d_r%0d", p, a), 64'(rbusy[p]), 64'(exp_b));
    end
    check("busy_cnt", 64'(busy_cnt), 64'(ref_count()));
  endtask

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] d, input logic ie,
                       input logic [AW-1:0] ia, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1);
    rst_n    = r;
    wr_en    = we;
    waddr    = wa;
    wd       = d;
    iss_en   = ie;
    iss_addr = ia;
    raddr    = {a1, a0};
    #1;
    check_outputs();
  endtask

  // One clock edge: apply the architectural rules to the model using the
  // inputs the DUT sampled, then return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        ref_reg[i]  = '0;
        ref_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && waddr != 0) begin
        ref_reg[waddr]  = wd;
        ref_busy[waddr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) ref_busy[iss_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; waddr = '0; wd = '0;
    iss_en = 1'b0; iss_addr = '0; raddr = '0;
    @(negedge clk);
    tick();
    tick();

    // Reset state on every address and port.
    for (int a = 0; a < NREG; a++) begin
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, AW'(a), AW'((a + 1) % NREG));
      check("rst_rd_p0", 64'(rd_port(0)), 64'h0);
      tick();
    end
    check("rst_busy_cnt", 64'(busy_cnt), 64'h0);

    // Write r5, read on both ports next cycle.
    drive(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0, '0, 5, 5);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 5, 5);
    check("r5_p0", 64'(rd_port(0)), 64'hDEADBEEF);
    check("r5_p1", 64'(rd_port(1)), 64'hDEADBEEF);

    // Write to r0 is dropped.
    drive(1'b1, 1'b1, 0, 32'h1234, 1'b0, '0, 0, 0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 0, 0);
    check("r0_zero", 64'(rd_port(0)), 64'h0);

    // Issue r7, then write it back.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 7, 7, 0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 7, 0);
    check("r7_busy", 64'(rbusy[0]), 64'h1);
    check("r7_cnt1", 64'(busy_cnt), 64'h1);
    drive(1'b1, 1'b1, 7, 32'hA5A5A5A5, 1'b0, '0, 7, 0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 7, 0);
    check("r7_idle", 64'(rbusy[0]), 64'h0);
    check("r7_cnt0", 64'(busy_cnt), 64'h0);
    check("r7_data", 64'(rd_port(0)), 64'hA5A5A5A5);

    // Same-cycle issue and write on r3: issue wins; re-issue keeps count.
    drive(1'b1, 1'b1, 3, 32'h55, 1'b1, 3, 3, 0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 3, 0);
    check("r3_data", 64'(rd_port(0)), 64'h55);
    check("r3_busy", 64'(rbusy[0]), 64'h1);
    check("r3_cnt", 64'(busy_cnt), 64'h1);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 3, 3, 0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 3, 0);
    check("r3_reissue_cnt", 64'(busy_cnt), 64'h1);

    // Read r9 while it is being written.
    drive(1'b1, 1'b1, 9, 32'h77, 1'b0, '0, 9, 9);
`ifdef REGFILE_BYPASS_EN
    check("r9_same_cycle", 64'(rd_port(0)), 64'h77);
`else
    check("r9_same_cycle", 64'(rd_port(0)), 64'h0);
`endif
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 9, 9);
    check("r9_next_cycle", 64'(rd_port(1)), 64'h77);

    // Reset mid-operation with busy registers and a write in flight.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, '0, '0, 1'b1, AW'(i), AW'(i), 0);
      tick();
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1, 4);
    check("mid_cnt4", 64'(busy_cnt), 64'h4);
    drive(1'b1, 1'b1, 2, 32'h9, 1'b0, '0, 2, 4);
    tick();
    drive(1'b0, 1'b1, 4, 32'hF, 1'b1, 6, 2, 4);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 2, 4);
    check("mid_r2", 64'(rd_port(0)), 64'h0);
    check("mid_r4", 64'(rd_port(1)), 64'h0);
    check("mid_busy", 64'(rbusy), 64'h0);
    check("mid_cnt0", 64'(busy_cnt), 64'h0);
    tick();

    // Randomized traffic; small address pool most of the time for collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ia, a0, a1;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
      ia = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 1) == 0) ? ia : AW'($urandom_range(0, NREG - 1));
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), wa,
            XLEN'($urandom), ($urandom_range(0, 9) < 4), ia, a0, a1);
      tick();
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
